// File: rtl/adder_check_pkg.sv
// Shared types and constants for the adder golden-model checker.
// Optional build macro: ADDER_CHECK_STOP_ON_ERR_EN (adds the HALT behaviour).
package adder_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 16;

endpackage

// File: rtl/adder_check_if.sv
// Operand, DUT-result and status bundle between the bench-side driver and the checker.
// Optional build macro: ADDER_CHECK_STOP_ON_ERR_EN (drives first_fail_a/first_fail_b).
interface adder_check_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);

  logic             clr;
  logic             in_valid;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  logic             exp_valid;
  logic [WIDTH-1:0] Sum_verify;
  logic             C_out_verify;
  logic             mismatch;
  logic [CNT_W-1:0] chk_count;
  logic [CNT_W-1:0] err_count;
  logic             sticky_fail;
  logic             busy;
  logic [WIDTH-1:0] first_fail_a;
  logic [WIDTH-1:0] first_fail_b;

  modport master (
    output clr, in_valid, op, A, B, C_in, dut_sum, dut_cout,
    input  exp_valid, Sum_verify, C_out_verify, mismatch, chk_count, err_count,
           sticky_fail, busy, first_fail_a, first_fail_b
  );

  modport slave (
    input  clr, in_valid, op, A, B, C_in, dut_sum, dut_cout,
    output exp_valid, Sum_verify, C_out_verify, mismatch, chk_count, err_count,
           sticky_fail, busy, first_fail_a, first_fail_b
  );

endinterface

// File: rtl/adder_check_delay.sv
// Valid+data shift register with per-stage valid and synchronous flush.
// Optional build macro: ADDER_CHECK_STOP_ON_ERR_EN (only widens DW at the instantiation site).
module adder_check_delay #(
  parameter int DEPTH = 2,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          any_valid
);

  logic [DEPTH-1:0] vld;
  logic [DW-1:0]    data [DEPTH];

  // A stage only loads when a valid entry arrives, so the output holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      if (in_valid) data[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) data[i] <= data[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign any_valid = |vld;

endmodule

// File: rtl/adder_check_pipe.sv
// Clocked golden-model checker: computes A+B(+C_in) or A+~B+C_in, aligns it to the DUT latency, compares, counts.
// Optional build macro: ADDER_CHECK_STOP_ON_ERR_EN (halt on first mismatch, latch its operands).
module adder_check_pipe
  import adder_check_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input logic        clk,
  input logic        rst,
  adder_check_if.slave bus
);

  localparam int DEPTH = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
`ifdef ADDER_CHECK_STOP_ON_ERR_EN
  localparam int DW = 3 * WIDTH + 1;
`else
  localparam int DW = WIDTH + 1;
`endif

  state_t           state, state_next;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   calc;
  logic [DW-1:0]    pipe_in, pipe_out;
  logic             pipe_valid, any_valid, accept;
  logic             cmp_en, cmp_fail;
  logic             mismatch_r, sticky_r;
  logic [CNT_W-1:0] chk_r, err_r;

  // Full WIDTH+1 result so the carry is the real carry bit, never a truncated one.
  always_comb begin
    b_eff = (bus.op == OP_ADD) ? bus.B : ~bus.B;
    calc  = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.C_in};
  end

  assign accept = bus.in_valid && !bus.clr && (state != HALT);
`ifdef ADDER_CHECK_STOP_ON_ERR_EN
  assign pipe_in = {calc, bus.A, bus.B};
`else
  assign pipe_in = calc;
`endif

  adder_check_delay #(.DEPTH(DEPTH), .DW(DW)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.clr),
    .in_valid (accept),
    .in_data  (pipe_in),
    .out_valid(pipe_valid),
    .out_data (pipe_out),
    .any_valid(any_valid)
  );

  assign cmp_en   = pipe_valid && !bus.clr && (state != HALT);
  assign cmp_fail = cmp_en && (pipe_out[DW-1 -: WIDTH+1] != {bus.dut_cout, bus.dut_sum});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.clr) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) state_next = RUN;
        RUN: begin
          if (!any_valid && !bus.in_valid) state_next = IDLE;
`ifdef ADDER_CHECK_STOP_ON_ERR_EN
          if (cmp_fail) state_next = HALT;
`endif
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Counters saturate at all-ones; a clr in the compare cycle discards that comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_r      <= '0;
      err_r      <= '0;
      sticky_r   <= 1'b0;
      mismatch_r <= 1'b0;
    end else if (bus.clr) begin
      chk_r      <= '0;
      err_r      <= '0;
      sticky_r   <= 1'b0;
      mismatch_r <= 1'b0;
    end else begin
      mismatch_r <= cmp_fail;
      if (cmp_en && chk_r != '1) chk_r <= chk_r + 1'b1;
      if (cmp_fail) begin
        sticky_r <= 1'b1;
        if (err_r != '1) err_r <= err_r + 1'b1;
      end
    end
  end

`ifdef ADDER_CHECK_STOP_ON_ERR_EN
  logic [WIDTH-1:0] ff_a, ff_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_a <= '0;
      ff_b <= '0;
    end else if (bus.clr) begin
      ff_a <= '0;
      ff_b <= '0;
    end else if (cmp_fail && state == RUN) begin
      ff_a <= pipe_out[2*WIDTH-1 -: WIDTH];
      ff_b <= pipe_out[WIDTH-1:0];
    end
  end

  assign bus.first_fail_a = ff_a;
  assign bus.first_fail_b = ff_b;
`else
  assign bus.first_fail_a = '0;
  assign bus.first_fail_b = '0;
`endif

  assign bus.exp_valid    = pipe_valid;
  assign bus.C_out_verify = pipe_out[DW-1];
  assign bus.Sum_verify   = pipe_out[DW-2 -: WIDTH];
  assign bus.mismatch     = mismatch_r;
  assign bus.chk_count    = chk_r;
  assign bus.err_count    = err_r;
  assign bus.sticky_fail  = sticky_r;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_adder_check_pipe.sv
// Directed bench for adder_check_pipe: 64-bit/latency-2 instance plus an 8-bit/latency-3/CNT_W=4 saturation instance.
// Expectations for ADDER_CHECK_STOP_ON_ERR_EN builds are selected with the same macro.
module tb_adder_check_pipe;
  import adder_check_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  adder_check_if #(.WIDTH(64), .CNT_W(16)) bus0 ();
  adder_check_if #(.WIDTH(8),  .CNT_W(4))  bus1 ();

  adder_check_pipe #(.WIDTH(64), .LATENCY(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  adder_check_pipe #(.WIDTH(8), .LATENCY(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic op, input logic [63:0] a, input logic [63:0] b, input logic cin);
    bus0.in_valid = 1'b1;
    bus0.op       = op;
    bus0.A        = a;
    bus0.B        = b;
    bus0.C_in     = cin;
  endtask

  logic        seen;
  logic [63:0] bad_a [4];
  logic [63:0] bad_b [4];

  initial begin
    bus0.clr = 0; bus0.in_valid = 0; bus0.op = 0; bus0.A = 0; bus0.B = 0; bus0.C_in = 0;
    bus0.dut_sum = 0; bus0.dut_cout = 0;
    bus1.clr = 0; bus1.in_valid = 0; bus1.op = 0; bus1.A = 0; bus1.B = 0; bus1.C_in = 0;
    bus1.dut_sum = 0; bus1.dut_cout = 0;

    // Reset state
    #2;
    checkOutput("rst_exp_valid", bus0.exp_valid, 0);
    checkOutput("rst_sum", bus0.Sum_verify, 0);
    checkOutput("rst_chk", bus0.chk_count, 0);
    checkOutput("rst_busy", bus0.busy, 0);
    checkOutput("rst_sticky", bus0.sticky_fail, 0);
    checkOutput("rst_err1", bus1.err_count, 0);
    step(); step();
    rst = 1'b0;
    step();

    // All-ones + 0 + carry-in wraps to 0 with carry-out 1
    applyStimulus(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    step();
    bus0.in_valid = 1'b0;
    checkOutput("t1_busy", bus0.busy, 1);
    checkOutput("t1_early", bus0.exp_valid, 0);
    step();
    checkOutput("t1_exp_valid", bus0.exp_valid, 1);
    checkOutput("t1_sum", bus0.Sum_verify, 0);
    checkOutput("t1_cout", bus0.C_out_verify, 1);
    bus0.dut_sum = 64'h0; bus0.dut_cout = 1'b1;
    step();
    checkOutput("t1_mismatch", bus0.mismatch, 0);
    checkOutput("t1_chk", bus0.chk_count, 1);
    checkOutput("t1_err", bus0.err_count, 0);

    // 5 - 7 gives -2 with a borrow (carry 0)
    applyStimulus(OP_SUB, 64'd5, 64'd7, 1'b1);
    step();
    bus0.in_valid = 1'b0;
    step();
    checkOutput("t2_sum", bus0.Sum_verify, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("t2_cout", bus0.C_out_verify, 0);
    bus0.dut_sum = 64'hFFFF_FFFF_FFFF_FFFE; bus0.dut_cout = 1'b0;
    step();
    checkOutput("t2_mismatch", bus0.mismatch, 0);
    checkOutput("t2_chk", bus0.chk_count, 2);

    // 1 + 1 against a DUT that answers 3
    applyStimulus(OP_ADD, 64'd1, 64'd1, 1'b0);
    step();
    bus0.in_valid = 1'b0;
    step();
    checkOutput("t3_sum", bus0.Sum_verify, 2);
    bus0.dut_sum = 64'd3; bus0.dut_cout = 1'b0;
    step();
    checkOutput("t3_mismatch", bus0.mismatch, 1);
    checkOutput("t3_err", bus0.err_count, 1);
    checkOutput("t3_sticky", bus0.sticky_fail, 1);
    checkOutput("t3_chk", bus0.chk_count, 3);
    step();
    checkOutput("t3_pulse_end", bus0.mismatch, 0);

    bus0.clr = 1'b1;
    step();
    bus0.clr = 1'b0;
    checkOutput("clr_chk", bus0.chk_count, 0);
    checkOutput("clr_err", bus0.err_count, 0);
    checkOutput("clr_sticky", bus0.sticky_fail, 0);
    checkOutput("clr_busy", bus0.busy, 0);

    // Four back-to-back operations emerge in order two cycles later
    for (int c = 0; c < 8; c++) begin
      if (c < 4) applyStimulus(OP_ADD, 64'd100 + 64'(c), 64'(c), 1'b0);
      else bus0.in_valid = 1'b0;
      if (c >= 2 && c < 6) begin
        checkOutput($sformatf("b2b_valid_%0d", c), bus0.exp_valid, 1);
        checkOutput($sformatf("b2b_sum_%0d", c), bus0.Sum_verify, 64'd100 + 64'(2 * (c - 2)));
        bus0.dut_sum = 64'd100 + 64'(2 * (c - 2));
        bus0.dut_cout = 1'b0;
      end else begin
        checkOutput($sformatf("b2b_idle_%0d", c), bus0.exp_valid, 0);
      end
      step();
    end
    checkOutput("b2b_chk", bus0.chk_count, 4);
    checkOutput("b2b_err", bus0.err_count, 0);

    // clr wins over a simultaneous in_valid
    applyStimulus(OP_ADD, 64'd10, 64'd20, 1'b0);
    bus0.clr = 1'b1;
    step();
    bus0.clr = 1'b0;
    bus0.in_valid = 1'b0;
    step();
    checkOutput("clrv_exp_valid", bus0.exp_valid, 0);
    checkOutput("clrv_chk", bus0.chk_count, 0);
    checkOutput("clrv_err", bus0.err_count, 0);

    // Reset with two operations in flight
    applyStimulus(OP_ADD, 64'd40, 64'd2, 1'b0);
    step();
    applyStimulus(OP_ADD, 64'd50, 64'd3, 1'b0);
    step();
    bus0.in_valid = 1'b0;
    checkOutput("rstm_pre_sum", bus0.Sum_verify, 42);
    rst = 1'b1;
    #1;
    checkOutput("rstm_exp_valid", bus0.exp_valid, 0);
    checkOutput("rstm_sum", bus0.Sum_verify, 0);
    checkOutput("rstm_busy", bus0.busy, 0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      seen = seen | bus0.exp_valid;
      step();
    end
    checkOutput("rstm_no_exp", seen, 0);

    // Four failing operations; first is A=9, B=4
    bad_a[0] = 64'd9; bad_b[0] = 64'd4;
    bad_a[1] = 64'd1; bad_b[1] = 64'd2;
    bad_a[2] = 64'd3; bad_b[2] = 64'd3;
    bad_a[3] = 64'd5; bad_b[3] = 64'd6;
    bus0.dut_sum = 64'd0; bus0.dut_cout = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(OP_ADD, bad_a[c], bad_b[c], 1'b0);
      step();
    end
    bus0.in_valid = 1'b0;
    for (int c = 0; c < 6; c++) step();
`ifdef ADDER_CHECK_STOP_ON_ERR_EN
    checkOutput("halt_err", bus0.err_count, 1);
    checkOutput("halt_chk", bus0.chk_count, 1);
    checkOutput("halt_ff_a", bus0.first_fail_a, 9);
    checkOutput("halt_ff_b", bus0.first_fail_b, 4);
    checkOutput("halt_busy", bus0.busy, 1);
`else
    checkOutput("bad4_err", bus0.err_count, 4);
    checkOutput("bad4_chk", bus0.chk_count, 4);
    checkOutput("bad4_ff_a", bus0.first_fail_a, 0);
    checkOutput("bad4_ff_b", bus0.first_fail_b, 0);
    checkOutput("bad4_busy", bus0.busy, 0);
`endif

    // Saturation on the 4-bit counters: 20 forced errors, latency 3
    bus1.dut_sum = 8'hFF; bus1.dut_cout = 1'b1;
    for (int c = 0; c < 25; c++) begin
      if (c < 20) begin
        bus1.in_valid = 1'b1;
        bus1.op = OP_ADD;
        bus1.A = 8'(c);
        bus1.B = 8'd0;
        bus1.C_in = 1'b0;
      end else begin
        bus1.in_valid = 1'b0;
      end
      if (c == 2) checkOutput("sat_lat_early", bus1.exp_valid, 0);
      if (c == 4) begin
        checkOutput("sat_lat_valid", bus1.exp_valid, 1);
        checkOutput("sat_lat_sum", bus1.Sum_verify, 1);
      end
      step();
    end
`ifdef ADDER_CHECK_STOP_ON_ERR_EN
    checkOutput("sat_err", bus1.err_count, 1);
    checkOutput("sat_chk", bus1.chk_count, 1);
`else
    checkOutput("sat_err", bus1.err_count, 15);
    checkOutput("sat_chk", bus1.chk_count, 15);
`endif
    checkOutput("sat_sticky", bus1.sticky_fail, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_check_pipe.md
Name: adder_check_pipe

Overview:
Clocked, parametrised golden-model checker for adder/ALU DUTs in the lab verification flow. It captures operands on a valid strobe and computes the correct WIDTH+1-bit result, with carry-out taken from the true carry bit. It delays the expected result to match the DUT pipeline latency, compares it against the DUT outputs, and keeps pass/fail statistics. It sits in the testbench beside the DUT and replaces the old unclocked `#`-delay verifier.

Parameters:
WIDTH, 64, operand and sum width in bits (legal 1..128)
LATENCY, 2, DUT latency in clock cycles from operand valid to result valid (legal 1..16)
CNT_W, 16, width of the check and error counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear: counters, sticky flag, pipeline
in_valid  in  1  operands valid this cycle
op  in  1  0 = add, 1 = subtract
A  in  WIDTH  operand A
B  in  WIDTH  operand B
C_in  in  1  carry in
dut_sum  in  WIDTH  DUT sum, sampled when exp_valid=1
dut_cout  in  1  DUT carry-out, sampled when exp_valid=1
exp_valid  out  1  expected result valid this cycle
Sum_verify  out  WIDTH  expected sum
C_out_verify  out  1  expected carry-out
mismatch  out  1  one-cycle pulse when a comparison fails
chk_count  out  CNT_W  comparisons performed, saturating
err_count  out  CNT_W  failed comparisons, saturating
sticky_fail  out  1  set on any mismatch since reset/clr
busy  out  1  state != IDLE
first_fail_a  out  WIDTH  A of first failing op (macro only, else 0)
first_fail_b  out  WIDTH  B of first failing op (macro only, else 0)

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high; while high, every output is 0, all pipeline valids are 0, and state = IDLE.
- Arithmetic:
  - op=0: {C_out_verify, Sum_verify} = A + B + C_in, with all terms zero-extended to WIDTH+1.
  - op=1: {C_out_verify, Sum_verify} = A + ~B + C_in. C_in=1 gives A−B, and carry=1 means no borrow.
  - Computed in the capture stage; no truncation before the carry is extracted.
- Latency: for in_valid=1 in cycle t, exp_valid, Sum_verify and C_out_verify are driven in cycle t+LATENCY. All outputs are registered.
- Throughput: one operation per cycle, back-to-back; no backpressure. Expected data holds its value when exp_valid=0.
- Compare:
  - At each edge where exp_valid=1, dut_sum/dut_cout are compared to Sum_verify/C_out_verify.
  - chk_count increments. On inequality, err_count increments and sticky_fail is set.
  - mismatch pulses high in cycle t+LATENCY+1.
  - Counters saturate at all-ones and never wrap.
- clr: takes effect at the next edge. It zeroes the counters, sticky_fail, mismatch and all pipeline valids, and sets state = IDLE.
  - clr together with in_valid: clr wins and the operand is dropped.
  - clr in the same cycle as exp_valid: the comparison is discarded.
- State machine:
  - IDLE → RUN when in_valid=1.
  - RUN → IDLE when no pipeline entry is valid and in_valid=0.
  - RUN → HALT on a mismatch (macro only).
  - HALT is left only by rst or clr.
- Reset mid-operation: in-flight operations are lost, and no exp_valid follows the deassertion of rst.

Optional Feature:
ADDER_CHECK_STOP_ON_ERR_EN
- Defined:
  - The first mismatch moves the FSM to HALT and latches that operation's A and B into first_fail_a/first_fail_b.
  - In HALT, in_valid is ignored and chk_count/err_count freeze; the pipeline still drains, but no comparisons are made.
  - busy stays 1.
- Undefined: there is no HALT state, checking runs continuously, and first_fail_a/first_fail_b are tied to 0.

Decomposition:
- Package adder_check_pkg: FSM state enum (IDLE, RUN, HALT), op encodings OP_ADD=0 and OP_SUB=1, and the LATENCY legal-range constants.
- Sub-module adder_check_delay: a parametrised valid+data shift register (DEPTH, DW) with per-stage valid and synchronous flush. It carries {Sum, C_out, A, B} through LATENCY stages.

Test Plan:
- WIDTH=64, LATENCY=2, op=0, A=64'hFFFF_FFFF_FFFF_FFFF, B=0, C_in=1, DUT returning the same result → at t+2: Sum_verify=0, C_out_verify=1, exp_valid=1; chk_count=1, mismatch never asserts.
- op=1, A=5, B=7, C_in=1 → Sum_verify=64'hFFFF_FFFF_FFFF_FFFE, C_out_verify=0 at t+2.
- A=1, B=1, C_in=0, dut_sum=3 → mismatch pulse at t+3; err_count=1, sticky_fail=1.
- Four back-to-back in_valid cycles → exp_valid high for four consecutive cycles starting at t+2, in order.
- CNT_W=4 with 20 forced errors → err_count=15, chk_count=15.
- rst raised while two operations are in flight → all outputs 0 at once and no exp_valid afterwards.
- clr and in_valid in the same cycle → no exp_valid two cycles later and counters at 0.
- With ADDER_CHECK_STOP_ON_ERR_EN: first bad op A=9, B=4, then three more bad ops → err_count=1, first_fail_a=9, first_fail_b=4, busy=1, state HALT.
